// File: rtl/lvds_tx_scheduler.sv
// lvds_tx_scheduler: round-robin arbiter that shares one lvds_serializer between
// NUM_REQ parallel-word requesters. Each grant issues one word with a single-cycle
// tx_word_valid pulse. The scheduler then follows the frame through tx_frame_pulse
// and does not re-arm until the serializer has shifted out the whole word.
// Optional feature: define LVDS_TX_TRAIN_EN to send TRAIN_COUNT frames of
// TRAIN_WORD after reset, before arbitration starts.
module lvds_tx_scheduler #(
    parameter int                        PARALLEL_WIDTH = 8,
    parameter int                        NUM_REQ        = 4,
    parameter int                        FRAME_TIMEOUT  = 8,
    parameter logic [PARALLEL_WIDTH-1:0] TRAIN_WORD     = 8'hA5,
    parameter int                        TRAIN_COUNT    = 4
) (
    input  logic                               clk_serial,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*PARALLEL_WIDTH-1:0]  req_word,
    output logic [NUM_REQ-1:0]                 grant,
    output logic [PARALLEL_WIDTH-1:0]          tx_parallel_word,
    output logic                               tx_word_valid,
    input  logic                               tx_frame_pulse,
    output logic [$clog2(NUM_REQ)-1:0]         active_id,
    output logic                               busy,
    output logic                               timeout_err,
    output logic [15:0]                        frame_count,
    output logic                               train_done
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int TCNT_W = $clog2(FRAME_TIMEOUT) + 1;
    localparam int SCNT_W = $clog2(PARALLEL_WIDTH) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_FRAME,
        ST_SHIFT
`ifdef LVDS_TX_TRAIN_EN
        , ST_TRAIN
`endif
    } state_t;

`ifdef LVDS_TX_TRAIN_EN
    localparam int     TRN_W       = $clog2(TRAIN_COUNT) + 1;
    localparam state_t RESET_STATE = ST_TRAIN;
    logic [TRN_W-1:0] trn_cnt_q, trn_cnt_d;
    logic             trn_done_q, trn_done_d;
`else
    localparam state_t RESET_STATE = ST_IDLE;
    // The training configuration has no effect without the feature.
    logic unused_train_cfg;
    assign unused_train_cfg = ^{TRAIN_WORD, 32'(TRAIN_COUNT)};
`endif

    state_t                    state_q, state_d;
    logic [ID_W-1:0]           ptr_q, ptr_d;
    logic [NUM_REQ-1:0]        grant_q, grant_d;
    logic [PARALLEL_WIDTH-1:0] word_q, word_d;
    logic                      valid_q, valid_d;
    logic [ID_W-1:0]           id_q, id_d;
    logic [TCNT_W-1:0]         tcnt_q, tcnt_d;
    logic [SCNT_W-1:0]         scnt_q, scnt_d;
    logic                      terr_q, terr_d;
    logic [15:0]               fcnt_q, fcnt_d;

    logic                      sel_found;
    logic [ID_W-1:0]           sel_id;
    logic                      frame_end;
    logic                      frame_ok;

    // Index of the requester 'offset' places after 'base', wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) sum -= NUM_REQ;
        return ID_W'(sum);
    endfunction

    // Round-robin pick: the first set req bit at or after the pointer, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && req[rr_index(ptr_q, k)]) begin
                sel_found = 1'b1;
                sel_id    = rr_index(ptr_q, k);
            end
        end
    end

    // Next-state logic: issue, follow the frame, then release the serializer.
    always_comb begin
        // NOTE: every variable gets its default value first, so no path can infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = '0;
        valid_d   = 1'b0;
        word_d    = word_q;
        id_d      = id_q;
        tcnt_d    = tcnt_q;
        scnt_d    = scnt_q;
        terr_d    = terr_q;
        fcnt_d    = fcnt_q;
        frame_end = 1'b0;
        frame_ok  = 1'b0;
`ifdef LVDS_TX_TRAIN_EN
        trn_cnt_d  = trn_cnt_q;
        trn_done_d = trn_done_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_id;
                    word_d  = req_word[int'(sel_id)*PARALLEL_WIDTH +: PARALLEL_WIDTH];
                    valid_d = 1'b1;
                    id_d    = sel_id;
                    ptr_d   = (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tcnt_d  = '0;
                state_d = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                // A pulse that arrives on the last allowed cycle still counts as on time.
                if (tx_frame_pulse) begin
                    scnt_d  = SCNT_W'(PARALLEL_WIDTH - 1);
                    state_d = ST_SHIFT;
                end else if (tcnt_q == TCNT_W'(FRAME_TIMEOUT - 1)) begin
                    terr_d    = 1'b1;
                    frame_end = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (scnt_q == '0) begin
                    frame_end = 1'b1;
                    frame_ok  = 1'b1;
                end else begin
                    scnt_d = scnt_q - 1'b1;
                end
            end
`ifdef LVDS_TX_TRAIN_EN
            ST_TRAIN: begin
                word_d  = TRAIN_WORD;
                valid_d = 1'b1;
                id_d    = '0;
                state_d = ST_ISSUE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // A training frame counts as sent whether it completed or timed out.
        if (frame_end) begin
`ifdef LVDS_TX_TRAIN_EN
            if (trn_done_q) begin
                state_d = ST_IDLE;
                if (frame_ok) fcnt_d = fcnt_q + 16'd1;
            end else begin
                trn_cnt_d = trn_cnt_q + 1'b1;
                if (trn_cnt_q == TRN_W'(TRAIN_COUNT - 1)) begin
                    trn_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_TRAIN;
                end
            end
`else
            state_d = ST_IDLE;
            if (frame_ok) fcnt_d = fcnt_q + 16'd1;
`endif
        end
    end

    // State and output registers. Reset takes priority over every other update.
    always_ff @(posedge clk_serial) begin
        // NOTE: non-blocking assignments make every register sample values from before the edge.
        if (reset) begin
            state_q <= RESET_STATE;
            ptr_q   <= '0;
            grant_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            tcnt_q  <= '0;
            scnt_q  <= '0;
            terr_q  <= 1'b0;
            fcnt_q  <= '0;
`ifdef LVDS_TX_TRAIN_EN
            trn_cnt_q  <= '0;
            trn_done_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            tcnt_q  <= tcnt_d;
            scnt_q  <= scnt_d;
            terr_q  <= terr_d;
            fcnt_q  <= fcnt_d;
`ifdef LVDS_TX_TRAIN_EN
            trn_cnt_q  <= trn_cnt_d;
            trn_done_q <= trn_done_d;
`endif
        end
    end

    assign grant            = grant_q;
    assign tx_parallel_word = word_q;
    assign tx_word_valid    = valid_q;
    assign active_id        = id_q;
    assign busy             = (state_q != ST_IDLE);
    assign timeout_err      = terr_q;
    assign frame_count      = fcnt_q;
`ifdef LVDS_TX_TRAIN_EN
    assign train_done       = trn_done_q;
`else
    assign train_done       = 1'b1;
`endif

endmodule

// File: tb/tb_lvds_tx_scheduler.sv
// Testbench for lvds_tx_scheduler. A simple serializer model returns
// tx_frame_pulse SYNC_LAT cycles after each tx_word_valid. Expected grants,
// words and frame timings are hand-computed constants.
module tb_lvds_tx_scheduler;

    localparam int W        = 8;
    localparam int N        = 4;
    localparam int SYNC_LAT = 2;
    // Distance between back-to-back valid pulses: issue + sync + shift + idle.
    localparam int GAP      = 1 + SYNC_LAT + W + 1;
`ifdef LVDS_TX_TRAIN_EN
    localparam logic TRAIN_BUILD = 1'b1;
`else
    localparam logic TRAIN_BUILD = 1'b0;
`endif

    logic             clk_serial = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_word;
    logic [N-1:0]     grant;
    logic [W-1:0]     tx_parallel_word;
    logic             tx_word_valid;
    logic             tx_frame_pulse;
    logic [1:0]       active_id;
    logic             busy;
    logic             timeout_err;
    logic [15:0]      frame_count;
    logic             train_done;

    logic             model_en;
    logic             manual_pulse;
    logic             model_pulse = 1'b0;
    int               ser_pend    = 0;

    int               n_checks = 0;
    int               n_errors = 0;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] grant;
        logic [1:0]   id;
        logic [W-1:0] word;
    } arb_vec_t;

    arb_vec_t vecs [8];
    int       order [5] = '{0, 1, 2, 3, 0};

    lvds_tx_scheduler dut (
        .clk_serial       (clk_serial),
        .reset            (reset),
        .req              (req),
        .req_word         (req_word),
        .grant            (grant),
        .tx_parallel_word (tx_parallel_word),
        .tx_word_valid    (tx_word_valid),
        .tx_frame_pulse   (tx_frame_pulse),
        .active_id        (active_id),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .frame_count      (frame_count),
        .train_done       (train_done)
    );

    always #5 clk_serial = ~clk_serial;

    assign tx_frame_pulse = model_en ? model_pulse : manual_pulse;

    // Serializer model: frame-start pulse SYNC_LAT cycles after the valid pulse.
    always @(negedge clk_serial) begin
        model_pulse = 1'b0;
        if (ser_pend != 0) begin
            ser_pend = ser_pend - 1;
            if (ser_pend == 0) model_pulse = 1'b1;
        end
        if (tx_word_valid === 1'b1) ser_pend = SYNC_LAT;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk_serial);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            cyc();
            n++;
        end
        check({name, "_idle"}, busy, 1'b0);
    endtask

    task automatic wait_valid(input string name, output int cycles);
        cycles = 0;
        do begin
            cyc();
            cycles++;
        end while (tx_word_valid !== 1'b1 && cycles < 60);
        check({name, "_valid"}, tx_word_valid, 1'b1);
    endtask

    task automatic wait_train(input string name);
        int n = 0;
        while (train_done !== 1'b1 && n < 300) begin
            cyc();
            n++;
        end
        check({name, "_train_done"}, train_done, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, grant, '0);
        check({tag, "_valid"}, tx_word_valid, 1'b0);
        check({tag, "_word"}, tx_parallel_word, '0);
        check({tag, "_id"}, active_id, '0);
        check({tag, "_busy"}, busy, TRAIN_BUILD);
        check({tag, "_terr"}, timeout_err, 1'b0);
        check({tag, "_fcnt"}, frame_count, '0);
        check({tag, "_train_done"}, train_done, !TRAIN_BUILD);
    endtask

    initial begin
        int  n;
        int  gap;
        bit  word_ok;
        bit  extra_valid;

        // Grant sequence from pointer 3, which is where the single-requester test leaves it.
        vecs[0] = '{req: 4'b1111, grant: 4'b1000, id: 2'd3, word: 8'h44};
        vecs[1] = '{req: 4'b0110, grant: 4'b0010, id: 2'd1, word: 8'h22};
        vecs[2] = '{req: 4'b0011, grant: 4'b0001, id: 2'd0, word: 8'h11};
        vecs[3] = '{req: 4'b0001, grant: 4'b0001, id: 2'd0, word: 8'h11};
        vecs[4] = '{req: 4'b1010, grant: 4'b0010, id: 2'd1, word: 8'h22};
        vecs[5] = '{req: 4'b1100, grant: 4'b0100, id: 2'd2, word: 8'h3C};
        vecs[6] = '{req: 4'b0101, grant: 4'b0001, id: 2'd0, word: 8'h11};
        vecs[7] = '{req: 4'b1000, grant: 4'b1000, id: 2'd3, word: 8'h44};

        reset        = 1'b1;
        req          = '0;
        req_word     = {8'h44, 8'h3C, 8'h22, 8'h11};
        model_en     = 1'b1;
        manual_pulse = 1'b0;

        // Reset state.
        cyc(2);
        check_reset_outputs("rst");
        reset = 1'b0;
        wait_train("rst");

        // Single requester 2: grant and valid one cycle after req, then one full frame.
        req = 4'b0100;
        cyc();
        check("b_grant", grant, 4'b0100);
        check("b_valid", tx_word_valid, 1'b1);
        check("b_word", tx_parallel_word, 8'h3C);
        check("b_id", active_id, 2'd2);
        req         = '0;
        n           = 0;
        word_ok     = 1'b1;
        extra_valid = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            cyc();
            n++;
            if (busy === 1'b1 && tx_parallel_word !== 8'h3C) word_ok = 1'b0;
            if (tx_word_valid !== 1'b0) extra_valid = 1'b1;
        end
        check("b_word_stable", word_ok, 1'b1);
        check("b_single_valid", extra_valid, 1'b0);
        check("b_frame_len", n, GAP - 1);
        check("b_busy_after", busy, 1'b0);
        check("b_fcnt", frame_count, 16'd1);

        // Table of arbitration patterns, each issued from IDLE.
        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req;
            cyc();
            check($sformatf("c%0d_grant", i), grant, vecs[i].grant);
            check($sformatf("c%0d_id", i), active_id, vecs[i].id);
            check($sformatf("c%0d_word", i), tx_parallel_word, vecs[i].word);
            req = '0;
            wait_idle($sformatf("c%0d", i));
        end
        check("c_fcnt", frame_count, 16'd9);

        // Contention: all requesters held, pointer at 0, gaps set by the full frame.
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_valid($sformatf("d%0d", g), gap);
            check($sformatf("d%0d_grant", g), grant, 32'(1) << order[g]);
            if (g > 0) check($sformatf("d%0d_gap", g), gap, GAP);
        end
        req = '0;
        wait_idle("d");
        check("d_fcnt", frame_count, 16'd14);

        // Reset during SHIFT, then a new contention round must start at requester 0.
        req = 4'b1111;
        wait_valid("g_pre", gap);
        check("g_pre_grant", grant, 4'b0010);
        req = '0;
        cyc(5);
        check("g_in_shift", busy, 1'b1);
        reset = 1'b1;
        cyc();
        check_reset_outputs("g_rst");
        reset = 1'b0;
        wait_train("g");
        req = 4'b1111;
        wait_valid("g0", gap);
        check("g0_grant", grant, 4'b0001);
        wait_valid("g1", gap);
        check("g1_grant", grant, 4'b0010);
        check("g1_gap", gap, GAP);
        req = '0;
        wait_idle("g");
        check("g_fcnt", frame_count, 16'd2);

        // Late pulse on the last WAIT_FRAME cycle, plus stray pulses in SHIFT and IDLE.
        model_en = 1'b0;
        req      = 4'b0001;
        wait_valid("f", gap);
        check("f_grant", grant, 4'b0001);
        req = '0;
        cyc(7);
        check("f_pre_busy", busy, 1'b1);
        check("f_pre_terr", timeout_err, 1'b0);
        cyc();
        manual_pulse = 1'b1;
        cyc();
        manual_pulse = 1'b0;
        check("f_no_err", timeout_err, 1'b0);
        check("f_shift_busy", busy, 1'b1);
        cyc(2);
        manual_pulse = 1'b1;
        cyc();
        manual_pulse = 1'b0;
        n = 12;
        while (busy === 1'b1 && n < 60) begin
            cyc();
            n++;
        end
        check("f_frame_len", n, 17);
        check("f_fcnt", frame_count, 16'd3);
        check("f_terr", timeout_err, 1'b0);
        manual_pulse = 1'b1;
        cyc();
        manual_pulse = 1'b0;
        check("f_idle_pulse", busy, 1'b0);

        // Timeout with no pulse. WAIT_FRAME lasts FRAME_TIMEOUT cycles, so the error shows 9 cycles after valid.
        req = 4'b0001;
        wait_valid("e", gap);
        check("e_grant", grant, 4'b0001);
        req = '0;
        n   = 0;
        while (timeout_err !== 1'b1 && n < 30) begin
            cyc();
            n++;
        end
        check("e_err_latency", n, 9);
        check("e_busy", busy, 1'b0);
        check("e_fcnt", frame_count, 16'd3);
        model_en = 1'b1;
        req      = 4'b0010;
        wait_valid("e_next", gap);
        check("e_next_grant", grant, 4'b0010);
        req = '0;
        wait_idle("e_next");
        check("e_next_fcnt", frame_count, 16'd4);
        check("e_sticky", timeout_err, 1'b1);

`ifdef LVDS_TX_TRAIN_EN
        // Training: four A5 frames with no grants, then requester 1 is served.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req   = 4'b0010;
        n     = 0;
        gap   = 0;
        word_ok     = 1'b1;
        extra_valid = 1'b0;
        while (train_done !== 1'b1 && n < 300) begin
            cyc();
            n++;
            if (tx_word_valid === 1'b1) begin
                gap++;
                if (tx_parallel_word !== 8'hA5) word_ok = 1'b0;
            end
            if (grant !== '0 || active_id !== '0) extra_valid = 1'b1;
        end
        check("t_done", train_done, 1'b1);
        check("t_frames", gap, 4);
        check("t_word", word_ok, 1'b1);
        check("t_no_grant", extra_valid, 1'b0);
        check("t_fcnt0", frame_count, 16'd0);
        wait_valid("t", gap);
        check("t_grant", grant, 4'b0010);
        check("t_req_word", tx_parallel_word, 8'h22);
        req = '0;
        wait_idle("t");
        check("t_fcnt1", frame_count, 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
